// File: rtl/tcb_pkg.sv
// Shared TCB definitions: response record layout and its width helper.
package tcb_pkg;

    localparam int unsigned TCB_DBW = 32;

    // Response record at the default data width; {wen, rdt, err}, MSB first.
    typedef struct packed {
        logic               wen;
        logic [TCB_DBW-1:0] rdt;
        logic               err;
    } tcb_rsp_t;

    function automatic int unsigned tcb_rsp_width(input int unsigned dbw);
        return dbw + 2;
    endfunction

endpackage

// File: rtl/tcb_fifo.sv
// Synchronous circular FIFO with registered storage; output shows the head entry.
module tcb_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dat   = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_next(r_wptr);
            if (w_pop)  r_rptr <= ptr_next(r_rptr);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            assert (!(i_push && o_full));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_dat;
    end

endmodule

// File: rtl/tcb_man_cmd.sv
// TCB manager: valid/ready commands out as TCB transfers, responses collected
// into a FIFO; issue is credit-gated because TCB responses cannot be stalled.
module tcb_man_cmd
    import tcb_pkg::*;
#(
    parameter  int unsigned ABW = 32,
    parameter  int unsigned DBW = 32,
    parameter  int unsigned SLW = 8,
    parameter  int unsigned DLY = 1,
    parameter  int unsigned RFD = 4,
    localparam int unsigned BEW = DBW / SLW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_vld,
    output logic           cmd_rdy,
    input  logic           cmd_wen,
    input  logic [ABW-1:0] cmd_adr,
    input  logic [BEW-1:0] cmd_ben,
    input  logic [DBW-1:0] cmd_wdt,
    output logic           rsp_vld,
    input  logic           rsp_rdy,
    output logic           rsp_wen,
    output logic [DBW-1:0] rsp_rdt,
    output logic           rsp_err,
    output logic           tcb_vld,
    output logic           tcb_wen,
    output logic [ABW-1:0] tcb_adr,
    output logic [BEW-1:0] tcb_ben,
    output logic [DBW-1:0] tcb_wdt,
    input  logic           tcb_rdy,
    input  logic [DBW-1:0] tcb_rdt,
    input  logic           tcb_err
);

    localparam int unsigned RSPW = tcb_rsp_width(DBW);
    localparam int unsigned CW   = $clog2(RFD + 1);

    typedef struct packed {
        logic           wen;
        logic [DBW-1:0] rdt;
        logic           err;
    } rsp_t;

    logic [CW-1:0] r_cnt;
    logic          w_crd;
    logic          w_trn;
    logic          w_pop;
    logic          w_lvld;
    logic          w_lwen;
    logic          w_full;
    logic          w_empty;
    rsp_t          w_push_dat;
    rsp_t          w_pop_dat;

    // cnt covers transfers still in the latency pipeline plus FIFO entries,
    // so a granted transfer always has a FIFO slot waiting for it.
    assign w_crd   = (r_cnt < CW'(RFD));
    assign tcb_vld = cmd_vld & w_crd & ~rst;
    assign cmd_rdy = tcb_rdy & w_crd & ~rst;
    assign w_trn   = tcb_vld & tcb_rdy;
    assign w_pop   = rsp_vld & rsp_rdy;

    assign tcb_wen = cmd_wen;
    assign tcb_adr = cmd_adr;
    assign tcb_ben = cmd_ben;
    assign tcb_wdt = cmd_wdt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            if (w_trn && !w_pop) r_cnt <= r_cnt + CW'(1);
            else if (!w_trn && w_pop) r_cnt <= r_cnt - CW'(1);
            assert (r_cnt <= CW'(RFD));
            assert (!(w_lvld && w_full));
        end
    end

    generate
        if (DLY == 0) begin : g_nodly
            assign w_lvld = w_trn;
            assign w_lwen = tcb_wen;
        end else begin : g_dly
            logic [DLY-1:0] r_pvld;
            logic [DLY-1:0] r_pwen;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pvld <= '0;
                end else begin
                    r_pvld[0] <= w_trn;
                    for (int unsigned i = 1; i < DLY; i++) r_pvld[i] <= r_pvld[i-1];
                end
            end

            always_ff @(posedge clk) begin
                r_pwen[0] <= tcb_wen;
                for (int unsigned i = 1; i < DLY; i++) r_pwen[i] <= r_pwen[i-1];
            end

            assign w_lvld = r_pvld[DLY-1];
            assign w_lwen = r_pwen[DLY-1];
        end
    endgenerate

    always_comb begin
        w_push_dat.wen = w_lwen;
        w_push_dat.rdt = w_lwen ? '0 : tcb_rdt;
        w_push_dat.err = tcb_err;
    end

    tcb_fifo #(
        .WIDTH (RSPW),
        .DEPTH (RFD)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_lvld),
        .i_dat   (w_push_dat),
        .i_pop   (w_pop),
        .o_dat   (w_pop_dat),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rsp_vld = ~w_empty;
    assign rsp_wen = w_pop_dat.wen;
    assign rsp_rdt = w_pop_dat.rdt;
    assign rsp_err = w_pop_dat.err;

endmodule
